// File: rtl/rib_tcm_arb.sv
// Two-master RIB arbiter in front of a single TCM controller, with a one-entry response hold buffer.
// Optional master lock for atomic read-modify-write is enabled with `define RIB_ARB_LOCK_EN.
module rib_tcm_arb #(
  parameter int ARB_MODE = 0,
  parameter int ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic              i_m0_wrcs,
  input  logic [3:0]        i_m0_mask,
  input  logic [31:0]       i_m0_wdata,
  input  logic              i_m0_req,
  output logic              o_m0_gnt,
  output logic              o_m0_rsp,
  output logic [31:0]       o_m0_rdata,
  input  logic              i_m0_rdy,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic              i_m1_wrcs,
  input  logic [3:0]        i_m1_mask,
  input  logic [31:0]       i_m1_wdata,
  input  logic              i_m1_req,
  output logic              o_m1_gnt,
  output logic              o_m1_rsp,
  output logic [31:0]       o_m1_rdata,
  input  logic              i_m1_rdy,
`ifdef RIB_ARB_LOCK_EN
  input  logic              i_m0_lock,
  input  logic              i_m1_lock,
`endif
  output logic [ADDR_W-1:0] o_s_addr,
  output logic              o_s_wrcs,
  output logic [3:0]        o_s_mask,
  output logic [31:0]       o_s_wdata,
  output logic              o_s_req,
  input  logic              i_s_gnt,
  input  logic              i_s_rsp,
  input  logic [31:0]       i_s_rdata,
  output logic              o_s_rdy
);

  logic        out_vld;
  logic        out_id;
  logic        hold_vld;
  logic        hold_id;
  logic [31:0] hold_data;
  logic        rr_last;

  logic owner_rdy;
  logic hold_rdy;
  logic can_issue;
  logic req0_eff;
  logic req1_eff;
  logic winner;
  logic hs;
  logic rsp_take;

  assign owner_rdy = out_id  ? i_m1_rdy : i_m0_rdy;
  assign hold_rdy  = hold_id ? i_m1_rdy : i_m0_rdy;
  // Reset is folded in so no request leaks to the slave while i_rst is high.
  assign can_issue = ~i_rst & ~hold_vld & (~out_vld | (i_s_rsp & owner_rdy));

`ifdef RIB_ARB_LOCK_EN
  logic lock_vld;
  logic lock_id;

  assign req0_eff = i_m0_req & ~(lock_vld & lock_id);
  assign req1_eff = i_m1_req & ~(lock_vld & ~lock_id);

  // Only the lock owner can win while locked, so every handshake re-evaluates the lock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else if (hs) begin
      lock_vld <= winner ? i_m1_lock : i_m0_lock;
      lock_id  <= winner;
    end
  end
`else
  assign req0_eff = i_m0_req;
  assign req1_eff = i_m1_req;
`endif

  always_comb begin
    if (req0_eff & req1_eff)
      winner = (ARB_MODE == 1) ? 1'b0 : ~rr_last;
    else
      winner = ~req0_eff;
  end

  assign o_s_req   = can_issue & (req0_eff | req1_eff);
  assign hs        = o_s_req & i_s_gnt;
  assign o_m0_gnt  = hs & ~winner;
  assign o_m1_gnt  = hs & winner;
  assign o_s_addr  = winner ? i_m1_addr  : i_m0_addr;
  assign o_s_wrcs  = winner ? i_m1_wrcs  : i_m0_wrcs;
  assign o_s_mask  = winner ? i_m1_mask  : i_m0_mask;
  assign o_s_wdata = winner ? i_m1_wdata : i_m0_wdata;
  assign o_s_rdy   = 1'b1;

  // A pulse with nothing outstanding is a protocol error and is dropped.
  assign rsp_take = out_vld & i_s_rsp & ~hold_vld;

  always_comb begin
    o_m0_rsp   = 1'b0;
    o_m1_rsp   = 1'b0;
    o_m0_rdata = 32'd0;
    o_m1_rdata = 32'd0;
    if (hold_vld) begin
      if (hold_id) begin
        o_m1_rsp   = 1'b1;
        o_m1_rdata = hold_data;
      end else begin
        o_m0_rsp   = 1'b1;
        o_m0_rdata = hold_data;
      end
    end else if (rsp_take) begin
      if (out_id) begin
        o_m1_rsp   = 1'b1;
        o_m1_rdata = i_s_rdata;
      end else begin
        o_m0_rsp   = 1'b1;
        o_m0_rdata = i_s_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vld   <= 1'b0;
      out_id    <= 1'b0;
      hold_vld  <= 1'b0;
      hold_id   <= 1'b0;
      hold_data <= 32'd0;
      rr_last   <= 1'b1;
    end else begin
      if (hs) begin
        out_vld <= 1'b1;
        out_id  <= winner;
        rr_last <= winner;
      end else if (rsp_take) begin
        out_vld <= 1'b0;
      end
      // The TCM never repeats its pulse, so an unready owner's data is captured here.
      if (rsp_take & ~owner_rdy) begin
        hold_vld  <= 1'b1;
        hold_id   <= out_id;
        hold_data <= i_s_rdata;
      end else if (hold_vld & hold_rdy) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rib_tcm_arb.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks both
// against a transaction-level model built from queues of outstanding and held responses.
module tb_rib_tcm_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_addr [2];
  logic        m_wrcs [2];
  logic [3:0]  m_mask [2];
  logic [31:0] m_wdata[2];
  logic        m_req  [2];
  logic        m_rdy  [2];
  logic        s_gnt;
  logic        s_rsp;
  logic [31:0] s_rdata;

  logic        gnt0[2], gnt1[2], rsp0[2], rsp1[2];
  logic [31:0] rdata0[2], rdata1[2];
  logic [31:0] sa[2], swd[2];
  logic        swr[2], sreq[2], srdy[2];
  logic [3:0]  smask[2];

  int vectors = 0;
  int miscompares = 0;

  int          pend_q[2][$];
  logic [32:0] held_q[2][$];
  int          last_win[2];
  bit          hs_s[2];
  int          win_s[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rib_tcm_arb #(.ARB_MODE(g), .ADDR_W(32)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_addr(m_addr[0]), .i_m0_wrcs(m_wrcs[0]), .i_m0_mask(m_mask[0]),
      .i_m0_wdata(m_wdata[0]), .i_m0_req(m_req[0]), .o_m0_gnt(gnt0[g]),
      .o_m0_rsp(rsp0[g]), .o_m0_rdata(rdata0[g]), .i_m0_rdy(m_rdy[0]),
      .i_m1_addr(m_addr[1]), .i_m1_wrcs(m_wrcs[1]), .i_m1_mask(m_mask[1]),
      .i_m1_wdata(m_wdata[1]), .i_m1_req(m_req[1]), .o_m1_gnt(gnt1[g]),
      .o_m1_rsp(rsp1[g]), .o_m1_rdata(rdata1[g]), .i_m1_rdy(m_rdy[1]),
      .o_s_addr(sa[g]), .o_s_wrcs(swr[g]), .o_s_mask(smask[g]), .o_s_wdata(swd[g]),
      .o_s_req(sreq[g]), .i_s_gnt(s_gnt), .i_s_rsp(s_rsp), .i_s_rdata(s_rdata),
      .o_s_rdy(srdy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model outputs at the falling edge, from current inputs and outstanding/held queues.
  task automatic sample();
    @(negedge clk);
    for (int md = 0; md < 2; md++) begin
      bit hold, busy, orr, ok, e_sreq, e_hs;
      bit e_rsp[2];
      logic [31:0] e_rd[2];
      int win, own;
      hold = held_q[md].size() != 0;
      busy = pend_q[md].size() != 0;
      orr  = busy ? m_rdy[pend_q[md][0]] : 1'b0;
      ok   = !rst && !hold && (!busy || (s_rsp && orr));
      if (m_req[0] && m_req[1]) win = (md == 1) ? 0 : 1 - last_win[md];
      else win = m_req[0] ? 0 : 1;
      e_sreq = ok && (m_req[0] || m_req[1]);
      e_hs   = e_sreq && s_gnt;
      e_rsp  = '{1'b0, 1'b0};
      e_rd   = '{32'd0, 32'd0};
      own    = -1;
      if (!rst && hold) begin
        own = int'(held_q[md][0][32]);
        e_rsp[own] = 1'b1;
        e_rd[own]  = held_q[md][0][31:0];
      end else if (!rst && busy) begin
        own = pend_q[md][0];
        if (s_rsp) begin
          e_rsp[own] = 1'b1;
          e_rd[own]  = s_rdata;
        end
      end
      chk($sformatf("m%0d_sreq", md), 64'(sreq[md]), 64'(e_sreq));
      chk($sformatf("m%0d_gnt0", md), 64'(gnt0[md]), 64'(e_hs && win == 0));
      chk($sformatf("m%0d_gnt1", md), 64'(gnt1[md]), 64'(e_hs && win == 1));
      chk($sformatf("m%0d_rsp0", md), 64'(rsp0[md]), 64'(e_rsp[0]));
      chk($sformatf("m%0d_rsp1", md), 64'(rsp1[md]), 64'(e_rsp[1]));
      if (e_rsp[0] || own != 0) chk($sformatf("m%0d_rdata0", md), 64'(rdata0[md]), 64'(e_rd[0]));
      if (e_rsp[1] || own != 1) chk($sformatf("m%0d_rdata1", md), 64'(rdata1[md]), 64'(e_rd[1]));
      chk($sformatf("m%0d_srdy", md), 64'(srdy[md]), 64'd1);
      if (e_sreq) begin
        chk($sformatf("m%0d_saddr", md), 64'(sa[md]), 64'(m_addr[win]));
        chk($sformatf("m%0d_swrcs", md), 64'(swr[md]), 64'(m_wrcs[win]));
        chk($sformatf("m%0d_smask", md), 64'(smask[md]), 64'(m_mask[win]));
        chk($sformatf("m%0d_swdata", md), 64'(swd[md]), 64'(m_wdata[win]));
      end
      hs_s[md]  = e_hs;
      win_s[md] = win;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int md = 0; md < 2; md++) begin
      if (rst) begin
        pend_q[md].delete();
        held_q[md].delete();
        last_win[md] = 1;
      end else begin
        if (held_q[md].size() != 0) begin
          if (m_rdy[int'(held_q[md][0][32])]) void'(held_q[md].pop_front());
        end else if (pend_q[md].size() != 0 && s_rsp) begin
          int p;
          p = pend_q[md].pop_front();
          if (!m_rdy[p]) held_q[md].push_back({p[0], s_rdata});
        end
        if (hs_s[md]) begin
          pend_q[md].push_back(win_s[md]);
          last_win[md] = win_s[md];
        end
      end
    end
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      m_req[k] = 1'b0; m_wrcs[k] = 1'b0; m_mask[k] = 4'hF;
      m_addr[k] = 32'd0; m_wdata[k] = 32'd0; m_rdy[k] = 1'b1;
    end
    s_gnt = 1'b1; s_rsp = 1'b0; s_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_req[0] = 1'b1; m_req[1] = 1'b1;
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("rst_sreq", 64'(sreq[d]), 64'd0);
      chk("rst_gnt", 64'({gnt0[d], gnt1[d], rsp0[d], rsp1[d]}), 64'd0);
      chk("rst_rdata", 64'({rdata0[d], rdata1[d]}), 64'd0);
    end
    tick();
    idle();
    rst = 1'b0;
  endtask

  initial begin
    last_win = '{1, 1};
    rst = 1'b1;
    idle();
    do_reset();

    // single master read
    m_req[0] = 1'b1; m_addr[0] = 32'h100;
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("single_gnt0", 64'(gnt0[d]), 64'd1);
      chk("single_addr", 64'(sa[d]), 64'h100);
    end
    tick();
    m_req[0] = 1'b0; s_rsp = 1'b1; s_rdata = 32'hDEADBEEF;
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("single_rsp0", 64'(rsp0[d]), 64'd1);
      chk("single_rdata0", 64'(rdata0[d]), 64'hDEADBEEF);
      chk("single_rsp1", 64'(rsp1[d]), 64'd0);
    end
    tick();
    s_rsp = 1'b0;
    sample();
    chk("single_rsp_end", 64'(rsp0[0]), 64'd0);
    tick();

    // contention, back-to-back
    do_reset();
    m_req[0] = 1'b1; m_req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rsp = (i > 0); s_rdata = $urandom;
      m_addr[0] = 32'h200 + 32'(i); m_addr[1] = 32'h280 + 32'(i);
      sample();
      chk("rr_gnt0", 64'(gnt0[0]), 64'(i % 2 == 0));
      chk("rr_gnt1", 64'(gnt1[0]), 64'(i % 2 == 1));
      chk("fp_gnt0", 64'(gnt0[1]), 64'd1);
      if (i > 0) begin
        chk("rr_rsp_route", 64'({rsp1[0], rsp0[0]}), (i % 2 == 1) ? 64'd1 : 64'd2);
        chk("fp_rsp_route", 64'({rsp1[1], rsp0[1]}), 64'd1);
      end
      tick();
    end
    m_req[0] = 1'b0; s_rsp = 1'b1; s_rdata = 32'h0000_5555;
    sample();
    chk("fp_gnt1_after_drop", 64'(gnt1[1]), 64'd1);
    chk("rr_rsp1_last", 64'(rsp1[0]), 64'd1);
    tick();
    m_req[1] = 1'b0;
    step();
    s_rsp = 1'b0;
    step();

    // backpressure on m1
    do_reset();
    m_req[1] = 1'b1; m_addr[1] = 32'h300;
    sample();
    chk("bp_gnt1", 64'(gnt1[0]), 64'd1);
    tick();
    m_req[1] = 1'b0; m_req[0] = 1'b1; m_rdy[1] = 1'b0;
    s_rsp = 1'b1; s_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      sample();
      for (int d = 0; d < 2; d++) begin
        chk("bp_rsp1", 64'(rsp1[d]), 64'd1);
        chk("bp_rdata1", 64'(rdata1[d]), 64'h12345678);
        chk("bp_no_sreq", 64'(sreq[d]), 64'd0);
      end
      tick();
      s_rsp = 1'b0; s_rdata = $urandom;
    end
    m_rdy[1] = 1'b1;
    sample();
    chk("bp_clear_rsp1", 64'(rsp1[0]), 64'd1);
    chk("bp_clear_no_sreq", 64'(sreq[0]), 64'd0);
    tick();
    sample();
    chk("bp_after_rsp1", 64'(rsp1[0]), 64'd0);
    chk("bp_next_gnt0", 64'(gnt0[0]), 64'd1);
    tick();
    m_req[0] = 1'b0; s_rsp = 1'b1;
    step();
    s_rsp = 1'b0;

    // write passthrough
    do_reset();
    m_req[0] = 1'b1; m_wrcs[0] = 1'b1; m_mask[0] = 4'b0101;
    m_wdata[0] = 32'hAABBCCDD; m_addr[0] = 32'h400;
    sample();
    chk("wr_wrcs", 64'(swr[0]), 64'd1);
    chk("wr_mask", 64'(smask[0]), 64'h5);
    chk("wr_wdata", 64'(swd[0]), 64'hAABBCCDD);
    tick();
    m_req[0] = 1'b0; s_rsp = 1'b1;
    step();
    s_rsp = 1'b0;

    // reset between grant and response
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h500;
    step();
    m_req[1] = 1'b1; rst = 1'b1;
    sample();
    chk("rstmid_sreq", 64'(sreq[0]), 64'd0);
    chk("rstmid_rsp0", 64'(rsp0[0]), 64'd0);
    tick();
    rst = 1'b0; s_rsp = 1'b1; s_rdata = 32'h0BAD0BAD;
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("stale_rsp", 64'({rsp0[d], rsp1[d]}), 64'd0);
      chk("first_tie_m0", 64'({gnt0[d], gnt1[d]}), 64'd2);
    end
    tick();
    idle(); s_rsp = 1'b1;
    step();
    s_rsp = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        m_req[k]   = ($urandom_range(0, 2) != 0);
        m_addr[k]  = $urandom;
        m_wrcs[k]  = 1'($urandom_range(0, 1));
        m_mask[k]  = 4'($urandom_range(0, 15));
        m_wdata[k] = $urandom;
        m_rdy[k]   = ($urandom_range(0, 3) != 0);
      end
      s_gnt   = ($urandom_range(0, 3) != 0);
      s_rsp   = 1'($urandom_range(0, 1));
      s_rdata = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
